// File: rtl/boolean_sweeper_if.sv
// rtl/boolean_sweeper_if.sv - stimulus/response bundle between the sweeper and its controller
interface boolean_sweeper_if;
    logic       start;
    logic       a_o;
    logic       b_o;
    logic       c_o;
    logic       d_i;
    logic       busy;
    logic       done;
    logic [7:0] table_o;
    logic       pass;
    logic [3:0] err_count;

    // Controller / function-under-test side: requests sweeps, returns d, observes results
    modport master (
        output start,
        output d_i,
        input  a_o,
        input  b_o,
        input  c_o,
        input  busy,
        input  done,
        input  table_o,
        input  pass,
        input  err_count
    );

    // Sweeper side: drives a/b/c, samples d, reports the table
    modport slave (
        input  start,
        input  d_i,
        output a_o,
        output b_o,
        output c_o,
        output busy,
        output done,
        output table_o,
        output pass,
        output err_count
    );
endinterface

// File: rtl/boolean_sweeper.sv
// rtl/boolean_sweeper.sv - exhaustive 3-input truth-table sweeper and checker
module boolean_sweeper #(
    parameter logic [7:0] EXPECTED = 8'h15,
    parameter int         SETTLE   = 1
) (
    input logic              clk,
    input logic              rst,
    boolean_sweeper_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    // Last WAIT count before moving to SAMPLE; SETTLE is limited to 1..15
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       a_q;
    logic       b_q;
    logic       c_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] table_q;
    logic       pass_q;
    logic [3:0] err_q;

    logic [7:0] captured;
    logic [3:0] err_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Table as it will look after the current SAMPLE edge, so the verdict
    // registered when entering DONE already includes vector 7
    always_comb begin
        captured      = table_q;
        captured[idx] = bus.d_i;
        err_next      = popcount8(captured ^ EXPECTED);
    end

    // Sweep sequencer: vector stepping, settle timing, capture and verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 3'd0;
            cnt     <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 8'h00;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    {a_q, b_q, c_q} <= 3'b000;
                    if (bus.start) begin
                        idx     <= 3'd0;
                        cnt     <= 4'd0;
                        table_q <= 8'h00;
                        pass_q  <= 1'b0;
                        err_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    {a_q, b_q, c_q} <= idx;
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_q <= captured;
                    if (idx == 3'd7) begin
                        err_q  <= err_next;
                        pass_q <= (err_next == 4'd0);
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx             <= idx + 3'd1;
                        cnt             <= 4'd0;
                        {a_q, b_q, c_q} <= idx + 3'd1;
                        state           <= WAIT;
                    end
                end
                DONE: begin
                    busy_q          <= 1'b0;
                    {a_q, b_q, c_q} <= 3'b000;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.c_o       = c_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_o   = table_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_boolean_sweeper.sv
// tb/tb_boolean_sweeper.sv - randomized self-checking bench for boolean_sweeper
module tb_boolean_sweeper;
    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       sel;
    logic [7:0] tt;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    boolean_sweeper_if s1 ();
    boolean_sweeper_if s2 ();

    assign s1.start = go & ~sel;
    assign s2.start = go & sel;
    assign s1.d_i   = tt[{s1.a_o, s1.b_o, s1.c_o}];
    assign s2.d_i   = tt[{s2.a_o, s2.b_o, s2.c_o}];

    boolean_sweeper #(.EXPECTED(8'h15), .SETTLE(1)) u_s1 (.clk(clk), .rst(rst), .bus(s1.slave));
    boolean_sweeper #(.EXPECTED(8'h15), .SETTLE(2)) u_s2 (.clk(clk), .rst(rst), .bus(s2.slave));

    logic [2:0] o_abc;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_tbl;
    logic       o_pass;
    logic [3:0] o_err;
    assign o_abc  = sel ? {s2.a_o, s2.b_o, s2.c_o} : {s1.a_o, s1.b_o, s1.c_o};
    assign o_busy = sel ? s2.busy : s1.busy;
    assign o_done = sel ? s2.done : s1.done;
    assign o_tbl  = sel ? s2.table_o : s1.table_o;
    assign o_pass = sel ? s2.pass : s1.pass;
    assign o_err  = sel ? s2.err_count : s1.err_count;

    // Truth table of a function given as a bit-level rule over a, b, c
    function automatic logic [7:0] make_table(input int kind);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            a = (i / 4) % 2 == 1;
            b = (i / 2) % 2 == 1;
            c = i % 2 == 1;
            case (kind)
                0:       t[i] = ~((a & b) | c);
                1:       t[i] = ~(a & b);
                default: t[i] = 1'b0;
            endcase
        end
        return t;
    endfunction

    function automatic int ref_errors(input logic [7:0] t);
        int n;
        logic [7:0] exp_t;
        exp_t = make_table(0);
        n = 0;
        for (int i = 0; i < 8; i++) if (t[i] != exp_t[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; sel = 1'b0; tt = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({s1.a_o, s1.b_o, s1.c_o, s1.busy, s1.done, s1.table_o, s1.pass, s1.err_count} !== 19'd0)
            $display("FAIL reset_s1: got %0h required 0",
                     {s1.a_o, s1.b_o, s1.c_o, s1.busy, s1.done, s1.table_o, s1.pass, s1.err_count});
        else n_pass++;
        n_checks++;
        if ({s2.a_o, s2.b_o, s2.c_o, s2.busy, s2.done, s2.table_o, s2.pass, s2.err_count} !== 19'd0)
            $display("FAIL reset_s2: got %0h required 0",
                     {s2.a_o, s2.b_o, s2.c_o, s2.busy, s2.done, s2.table_o, s2.pass, s2.err_count});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full sweep with cycle-by-cycle checks of stimulus, busy, done and partial table
    task automatic test_sweep(input logic [7:0] f, input logic s, input string nm);
        int st, last_drive, dcyc, k, m;
        st = s ? 2 : 1;
        last_drive = 8 * (st + 1);
        dcyc = last_drive + 1;
        tt = f; sel = s;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc <= last_drive) begin
                n_checks++;
                if (o_abc !== 3'((cyc - 1) / (st + 1)))
                    $display("FAIL %s_abc c%0d: got %0d required %0d", nm, cyc, o_abc, (cyc - 1) / (st + 1));
                else n_pass++;
            end
            if (cyc <= dcyc) begin
                k = (cyc - 1) / (st + 1);
                m = (1 << k) - 1;
                n_checks++;
                if (o_tbl !== (f & m[7:0]))
                    $display("FAIL %s_partial c%0d: got %h required %h", nm, cyc, o_tbl, f & m[7:0]);
                else n_pass++;
            end
            n_checks++;
            if (o_busy !== (cyc <= dcyc))
                $display("FAIL %s_busy c%0d: got %b required %b", nm, cyc, o_busy, cyc <= dcyc);
            else n_pass++;
            n_checks++;
            if (o_done !== (cyc == dcyc))
                $display("FAIL %s_done c%0d: got %b required %b", nm, cyc, o_done, cyc == dcyc);
            else n_pass++;
            if (cyc == dcyc) begin
                n_checks++;
                if (o_err !== 4'(ref_errors(f)))
                    $display("FAIL %s_err: got %0d required %0d", nm, o_err, ref_errors(f));
                else n_pass++;
                n_checks++;
                if (o_pass !== (ref_errors(f) == 0))
                    $display("FAIL %s_pass: got %b required %b", nm, o_pass, ref_errors(f) == 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            test_sweep(8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_ignore_start();
        int ndone, dat;
        logic [7:0] tbl_at;
        tt = make_table(0); sel = 1'b0; ndone = 0; dat = -1; tbl_at = 8'h00;
        go = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (o_done === 1'b1) begin
                ndone++; dat = cyc; tbl_at = o_tbl;
            end
            go = (cyc == 5 || cyc == 10);
        end
        go = 1'b0;
        n_checks++;
        if (ndone != 1 || dat != 17)
            $display("FAIL ignore_done: got %0d pulses at %0d required 1 at 17", ndone, dat);
        else n_pass++;
        n_checks++;
        if (tbl_at !== 8'h15) $display("FAIL ignore_table: got %h required 15", tbl_at);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        tt = make_table(0); sel = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (o_abc !== 3'd3) $display("FAIL midrst_vec: got %0d required 3", o_abc);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_abc, o_busy, o_done, o_tbl, o_pass, o_err} !== 19'd0)
            $display("FAIL midrst_zero: got %h required 0", {o_abc, o_busy, o_done, o_tbl, o_pass, o_err});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_sweep(make_table(0), 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd;
        tt = 8'h00; sel = 1'b0; d1 = -1; d2 = -1; nd = 0;
        go = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (o_done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = cyc; else if (nd == 2) d2 = cyc;
            end
            if (cyc == 18) begin
                n_checks++;
                if (o_err !== 4'd3) $display("FAIL b2b_held_err: got %0d required 3", o_err);
                else n_pass++;
            end
            if (cyc == 19) begin
                n_checks++;
                if (o_err !== 4'd0 || o_pass !== 1'b0)
                    $display("FAIL b2b_cleared: got err %0d pass %b required 0 0", o_err, o_pass);
                else n_pass++;
            end
            if (cyc == 39) go = 1'b0;
        end
        n_checks++;
        if (nd != 2 || d1 != 17 || d2 != 35)
            $display("FAIL b2b_done: got %0d pulses at %0d,%0d required 2 at 17,35", nd, d1, d2);
        else n_pass++;
        for (int w = 0; w < 40 && o_busy !== 1'b0; w++) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL b2b_idle: got busy %b required 0", o_busy);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sweep(make_table(0), 1'b0, "nominal");
        test_sweep(8'h00, 1'b0, "tied0");
        test_sweep(8'hFF, 1'b0, "tied1");
        test_sweep(make_table(1), 1'b1, "settle2_nand");
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/boolean_sweeper.md
# boolean_sweeper

Sequential exhaustive-stimulus driver and checker for the 3-input Boolean function blocks (d = ~((a&b)|c) family). On a start request it drives every input combination {a,b,c} = 0..7 into the function-under-test and samples its output d after a programmable settle time. It assembles the 8-entry truth table and compares it against an expected table. It is the driving and sampling end of the a/b/c→d interface, used for on-chip self-test of the combinational Boolean blocks.

## Interface
Parameters:
- EXPECTED, 8'h15, expected truth table; bit i = d for {a,b,c} = i (8'h15 is ~((a&b)|c))
- SETTLE, 1, cycles held on each vector before sampling; legal range 1..15

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  sweep request; sampled only in IDLE
- a_o  output  1  stimulus bit a (MSB of vector index)
- b_o  output  1  stimulus bit b
- c_o  output  1  stimulus bit c (LSB of vector index)
- d_i  input  1  output of function-under-test
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive
- done  output  1  one-cycle pulse, sweep complete
- table_o  output  8  captured truth table; bit i = sampled d_i for vector i
- pass  output  1  table_o == EXPECTED; valid from done, held until next accepted start
- err_count  output  4  number of bit positions where table_o != EXPECTED (0..8)

## Operation
- All outputs reset to 0. Reset is asynchronous and may assert in any state. It forces IDLE and clears idx, the settle counter, table_o, pass and err_count, and drives a_o/b_o/c_o to 0.
- State machine with states IDLE, WAIT, SAMPLE and DONE:
  - IDLE: a/b/c = 0. If start=1, then idx←0, cnt←0, table_o←0, pass←0, err_count←0, go to WAIT. Otherwise stay.
  - WAIT: {a_o,b_o,c_o} = idx (registered). cnt increments each cycle. When cnt == SETTLE-1, go to SAMPLE.
  - SAMPLE: the vector is still driven. At the edge leaving SAMPLE, table_o[idx]←d_i. If idx==7, go to DONE. Otherwise idx←idx+1, cnt←0, go to WAIT.
  - DONE: done=1 for exactly one cycle. pass and err_count are registered from the complete table. Go to IDLE.
- err_count = popcount(table_o ^ EXPECTED), computed from the final table. pass = (err_count == 0).
- start is ignored while busy. start held high continuously restarts a new sweep on the cycle after DONE returns to IDLE.
- idx is 3 bits and never wraps mid-sweep; sweep terminates after vector 7.
- table_o updates bit by bit during the sweep, so partial results are visible. It is final only when done=1.

## Timing
- The cycle in which start=1 is sampled in IDLE is cycle 0.
- Each vector occupies SETTLE cycles of WAIT plus 1 cycle of SAMPLE, i.e. SETTLE+1 cycles.
- Vector i is driven from cycle 1+i·(SETTLE+1) and is sampled at the end of cycle (i+1)·(SETTLE+1).
- done is high in cycle 8·(SETTLE+1)+1. With SETTLE=1 this is cycle 17; with SETTLE=2 it is cycle 25.
- busy is high for cycles 1 through 8·(SETTLE+1)+1 inclusive.
- a/b/c change only on the WAIT entry edge, so d_i has at least SETTLE+1 full cycles to settle before capture.
- No combinational path from d_i or start to any output.

## Test plan
- d_i driven by ~((a_o&b_o)|c_o), SETTLE=1, pulse start → done in cycle 17, table_o=8'h15, pass=1, err_count=0.
- d_i tied 0 → table_o=8'h00, err_count=3, pass=0. d_i tied 1 → table_o=8'hFF, err_count=5, pass=0.
- SETTLE=2, d_i = ~(a&b) (table 8'h3F) → done in cycle 25, a/b/c step every 3 cycles, err_count=3, pass=0.
- start re-pulsed at cycles 5 and 10 during a sweep → ignored; exactly one done at cycle 17, and the results match the first request.
- rst asserted mid-sweep while vector 3 is driven → all outputs 0 immediately; a later start yields a clean full sweep with table_o=8'h15 and pass=1.
- start held high for 40 cycles with SETTLE=1 → done pulses at cycles 17 and 35; pass and err_count are cleared at the second acceptance (cycle 18).
